// File: rtl/mycpu_pkg.sv
// Shared constants for the SRAM arbiter slice: response-owner encoding and SRAM timing.
package mycpu_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    localparam int SRAM_LATENCY = 1;

    localparam int STARVE_W = 4;

    function automatic logic [31:0] route_rdata(input logic [1:0] own,
                                                input logic [1:0] want,
                                                input logic       suppress,
                                                input logic [31:0] rdata);
        return ((own == want) && !suppress) ? rdata : 32'h0;
    endfunction

endpackage

// File: rtl/mycpu_starve_ctr.sv
// Saturating starvation counter: counts data grants taken while fetch waits, cleared when fetch wins.
module mycpu_starve_ctr
    import mycpu_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] cnt,
    output logic                at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    assign at_limit = (cnt == LIMIT_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mycpu_sram_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and MEM-stage data accesses,
// data-priority with a starvation override, routing 1-cycle responses to their issuer.
//
// resp_own | meaning
// ---------+------------------------------------------------
// NONE     | no access granted last cycle, no response due
// INST     | last cycle granted fetch, sram_rdata is for IF
// DATA     | last cycle granted data, rdata/ack is for MEM
module mycpu_sram_arbiter
    import mycpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;
    logic                force_inst;
    logic [1:0]          resp_own;
    logic                resp_is_store;
    logic [1:0]          own_next;

    assign force_inst = starve_hit & inst_req;
    assign data_gnt   = data_req & ~force_inst;
    assign inst_gnt   = inst_req & ~data_gnt;

    mycpu_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (data_gnt & inst_req),
        .clr      (inst_gnt),
        .cnt      (starve_cnt),
        .at_limit (starve_hit)
    );

    always_comb begin
        sram_en    = inst_gnt | data_gnt;
        sram_wen   = 4'b0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        own_next   = OWN_NONE;
        if (data_gnt) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            sram_wen   = data_wr ? data_wstrb : 4'b0;
            own_next   = OWN_DATA;
        end else if (inst_gnt) begin
            sram_addr  = inst_addr;
            own_next   = OWN_INST;
        end
    end

    // Reloaded every cycle so back-to-back grants need no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_own      <= OWN_NONE;
            resp_is_store <= 1'b0;
        end else begin
            resp_own      <= own_next;
            resp_is_store <= data_gnt & data_wr;
        end
    end

    assign inst_rvalid = (resp_own == OWN_INST);
    assign data_rvalid = (resp_own == OWN_DATA);
    assign inst_rdata  = route_rdata(resp_own, OWN_INST, 1'b0, sram_rdata);
    assign data_rdata  = route_rdata(resp_own, OWN_DATA, resp_is_store, sram_rdata);

endmodule

// File: doc/mycpu_sram_arbiter.md
# mycpu_sram_arbiter

Shares the single synchronous SRAM port between the instruction-fetch stage (PC unit) and the MEM-stage data access. It grants at most one requester per cycle, with data priority by default. A starvation counter guarantees fetch progress, and the block routes each 1-cycle-latency SRAM response back to the requester that issued it. It sits between the IF/MEM stages and the SRAM, so that a single SRAM-like port serves both.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants, taken while fetch was waiting, after which fetch is forced through; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- inst_req  in  1  fetch request (IF instRequest)
- inst_addr  in  32  fetch address (PC)
- inst_gnt  out  1  fetch accepted this cycle
- inst_rvalid  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  data access request
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  byte enables for stores
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_gnt  out  1  data access accepted this cycle
- data_rvalid  out  1  load data valid / store acknowledge
- data_rdata  out  32  load data
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid 1 cycle after sram_en

## Operation
- Grant logic is combinational from the requests and the starvation counter:
  - force = (starve_cnt == STARVE_LIMIT) & inst_req
  - data_gnt = data_req & ~force
  - inst_gnt = inst_req & ~data_gnt
- SRAM port mux:
  - sram_en = inst_gnt | data_gnt
  - On a data grant: sram_addr = data_addr, sram_wdata = data_wdata, sram_wen = data_wr ? data_wstrb : 4'b0.
  - On a fetch grant: sram_addr = inst_addr, sram_wen = 0, sram_wdata = 0.
  - When idle: all port outputs are 0.
- Response owner register resp_own (states NONE, INST, DATA):
  - Loaded every cycle with the owner of that cycle's grant, or NONE if no grant.
  - Back-to-back grants are legal every cycle; there is no bubble.
- Response routing:
  - inst_rvalid = (resp_own == INST)
  - data_rvalid = (resp_own == DATA); it pulses for stores too, as the store acknowledge.
  - inst_rdata = sram_rdata when resp_own == INST, else 0.
  - data_rdata = sram_rdata when resp_own == DATA and the granted access was a load, else 0.
- starve_cnt (4 bits):
  - +1 when data_gnt & inst_req, saturating at STARVE_LIMIT.
  - Cleared to 0 on inst_gnt.
  - Otherwise it holds.
- Simultaneous requests: data wins unless force is set, in which case fetch wins and data_gnt = 0 that cycle. The requester that loses must hold its request.
- Reset:
  - resp_own = NONE, starve_cnt = 0, so inst_rvalid = data_rvalid = 0.
  - Grants are not gated by rst; requesters are held idle during reset.
- Reset mid-operation: the in-flight response is discarded, and no rvalid is produced for it.

## Timing
- Grant and SRAM request occur in the same cycle as the request (0-cycle grant).
- Response arrives exactly 1 cycle after the grant.
- Throughput: 1 access per cycle total.
- Worst-case fetch wait under continuous data traffic: STARVE_LIMIT cycles, with the grant on cycle STARVE_LIMIT+1.
- Outputs after reset deassertion: rvalids 0 until the first grant + 1 cycle.

## Structure
- Shared package mycpu_pkg holds:
  - owner encoding constants OWN_NONE = 2'd0, OWN_INST = 2'd1, OWN_DATA = 2'd2
  - SRAM_LATENCY = 1
- The response tracker also registers a 1-bit resp_is_store alongside resp_own, to zero data_rdata on store acknowledges.
- One sub-module: mycpu_starve_ctr, the saturating counter with inc, clr and limit-reached output.

## Test plan
- Fetch only: inst_req=1 for 3 cycles at PCs 0xbfc00000/04/08
  - inst_gnt=1 each cycle
  - inst_rvalid on cycles 2–4 with the matching sram_rdata
  - data_rvalid=0 throughout
- Simultaneous single request: inst_req=1, data_req=1, load at 0x1000, counter 0
  - data_gnt=1 and inst_gnt=0
  - next cycle: data_rvalid=1 and starve_cnt=1
- Starvation: both requests held continuously with STARVE_LIMIT=4
  - data_gnt on cycles 1–4
  - inst_gnt on cycle 5, starve_cnt back to 0
  - data_gnt resumes on cycle 6
- Store: data_wr=1, data_wstrb=4'b0011, data_addr=0x2000, data_wdata=0xdeadbeef
  - sram_wen=0011 with the address and data passed through
  - next cycle: data_rvalid=1, data_rdata=0
- Interleave: alternate fetch-only and data-only every cycle
  - every cycle granted
  - each rvalid goes to the correct owner, with no cross-routing of rdata
- Reset mid-flight: assert rst in the cycle after a fetch grant
  - inst_rvalid stays 0
  - starve_cnt=0
  - the first grant after reset behaves as in the fetch-only case
